// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer for the UART datapath. Detects the start bit on the
// synchronized RX line, samples every bit at mid-bit (LSB first), assembles
// the frame and presents completed bytes on a valid/ready interface.
//
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data
// bits (PARITY state + parity_err port). Undefined: frame is 1+DATA_BITS+1.
//
// Ports
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   rx_en       in   receiver enable; low aborts any frame, holds IDLE
//   rx_sync     in   synchronized serial line, idle high
//   rx_data     out  received byte, valid while rx_valid=1
//   rx_valid    out  byte available, held until rx_ready
//   rx_ready    in   host accept
//   busy        out  FSM not in IDLE
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   overrun     out  1-cycle pulse: new byte dropped, previous unaccepted
//   parity_err  out  1-cycle pulse: parity mismatch (parity build only)
//
// State      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | line idle, waiting for a low level with rx_en=1
// S_START    | confirm start bit at half a bit-time
// S_DATA     | sample DATA_BITS data bits, one per bit-time
// S_PARITY   | sample and check parity bit (parity build only)
// S_STOP     | sample stop bit; high delivers, low flags framing error
// S_WAIT_HIGH| after a framing error, wait for the line to return high
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_en,
    input  logic                 rx_sync,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
            $error("uart_rx_ctrl: CLKS_PER_BIT must be even and >= 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
            $error("uart_rx_ctrl: DATA_BITS must be 5..9");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
            $error("uart_rx_ctrl: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [3:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  deliver;

    logic                  sample;
    logic                  cnt_clr;
    logic                  shift_en;
    logic                  stop_good;
    logic                  stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
    localparam logic       PAR_ODD = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sample    = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_sync) state_nx = S_START;
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    sample   = 1'b1;
                    state_nx = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    sample   = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == FULL_M1) begin
                    sample   = 1'b1;
                    // Even parity: data ones plus parity bit is even.
                    par_bad  = rx_sync != ((^shift_q) ^ PAR_ODD);
                    state_nx = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    sample = 1'b1;
                    if (rx_sync) begin
                        stop_good = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nx  = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Disable wins over everything: partial frame dropped silently.
        if (!rx_en) begin
            state_nx  = S_IDLE;
            shift_en  = 1'b0;
            stop_good = 1'b0;
            stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   = 1'b0;
`endif
        end
    end

    // Counter holds 0 while idle so the start edge begins counting from 0.
    assign cnt_clr = sample || (state_nx != state) ||
                     (state == S_IDLE) || (state == S_WAIT_HIGH);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            deliver    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;

            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_en) begin
                shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
            end

            deliver   <= stop_good;
            frame_err <= stop_bad;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
`endif

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            // Load overrides the accept-clear above when both happen together.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end
        end
    end

endmodule
